// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_pkg
// Purpose  : Shared constants for the cruise controller: change-request
//            encodings, alertness thresholds and parameter defaults.
// Revision : 1.0 - initial release
// ============================================================================
package control_pkg;

  // Driver change-request encodings
  localparam logic [1:0] c_chg_none   = 2'b00;
  localparam logic [1:0] c_chg_resume = 2'b01;
  localparam logic [1:0] c_chg_up     = 2'b10;
  localparam logic [1:0] c_chg_down   = 2'b11;

  // Alertness thresholds: 0 is unresponsive, 3 and above is fully trusted
  localparam logic [2:0] c_alert_off  = 3'd0;
  localparam logic [2:0] c_alert_full = 3'd3;

  // Parameter defaults for the controller
  localparam int c_def_max_speed  = 200;
  localparam int c_def_set_step   = 5;
  localparam int c_def_brake_step = 4;

endpackage : control_pkg
`default_nettype wire

// File: rtl/control_speed_comparator.sv
`default_nettype none
// ============================================================================
// Module   : speed_comparator
// Purpose  : Combinational unsigned 8-bit magnitude compare, one-hot result.
// Revision : 1.0 - initial release
// ============================================================================
module speed_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  // One-hot magnitude flags of a relative to b
  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule : speed_comparator
`default_nettype wire

// File: rtl/control.sv
`default_nettype none
// ============================================================================
// Module   : control
// Purpose  : Cruise-speed controller. Derives a new target speed from the
//            driver request, compares it with the current speed and issues
//            a registered brake / throttle command plus a predicted speed.
//            Optional macro CONTROL_ALERT_EN compiles in driver-alertness
//            gating of the change request; otherwise hooshyari is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module control
  import control_pkg::*;
#(
  parameter int MAX_SPEED  = c_def_max_speed,
  parameter int SET_STEP   = c_def_set_step,
  parameter int BRAKE_STEP = c_def_brake_step
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] speed,
  input  logic [7:0] vfeli,
  input  logic [2:0] hooshyari,
  input  logic [1:0] change,
  output logic       tormoz,
  output logic [2:0] pashesh,
  output logic       gt,
  output logic       eq,
  output logic       lt,
  output logic [1:0] changewire,
  output logic [7:0] vout1,
  output logic [7:0] vfelinew
);

  localparam logic [8:0] c_max        = 9'(MAX_SPEED);
  localparam logic [8:0] c_set_step   = 9'(SET_STEP);
  localparam logic [7:0] c_brake_step = 8'(BRAKE_STEP);

  logic [7:0] w_speed;
  logic [7:0] w_vfeli;
  logic       w_alert_off;
  logic [1:0] w_change;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_target;
  logic       w_gt;
  logic       w_eq;
  logic       w_lt;
  logic [7:0] w_up;
  logic [7:0] w_dn;
  logic       w_tormoz;
  logic [2:0] w_pashesh;
  logic [7:0] w_vfelinew;

  logic       r_tormoz;
  logic [2:0] r_pashesh;
  logic       r_gt;
  logic       r_eq;
  logic       r_lt;
  logic [1:0] r_changewire;
  logic [7:0] r_vout1;
  logic [7:0] r_vfelinew;

  // Clamp both speed inputs to MAX_SPEED before anything else sees them
  always_comb begin
    w_speed = ({1'b0, speed} > c_max) ? c_max[7:0] : speed;
    w_vfeli = ({1'b0, vfeli} > c_max) ? c_max[7:0] : vfeli;
  end

`ifdef CONTROL_ALERT_EN
  // Gate the request by alertness: none when unresponsive, no speed-up when drowsy
  always_comb begin
    w_alert_off = (hooshyari == c_alert_off);
    w_change    = change;
    if (w_alert_off) begin
      w_change = c_chg_none;
    end else if ((hooshyari < c_alert_full) && (change == c_chg_up)) begin
      w_change = c_chg_none;
    end
  end
`else
  logic w_unused_alert;

  // Alertness ignored: the driver is treated as fully alert
  always_comb begin
    w_alert_off    = 1'b0;
    w_change       = change;
    w_unused_alert = ^hooshyari;
  end
`endif

  // New target speed with saturation at 0 and MAX_SPEED using 9-bit math
  always_comb begin
    w_sum  = {1'b0, w_speed} + c_set_step;
    w_diff = {1'b0, w_speed} - c_set_step;
    case (w_change)
      c_chg_up:     w_target = (w_sum > c_max) ? c_max[7:0] : w_sum[7:0];
      c_chg_down:   w_target = w_diff[8] ? 8'd0 : w_diff[7:0];
      c_chg_resume: w_target = w_vfeli;
      default:      w_target = w_speed;
    endcase
    if (w_alert_off) begin
      w_target = 8'd0;
    end
  end

  speed_comparator u_cmp (
    .a  (w_vfeli),
    .b  (w_target),
    .gt (w_gt),
    .eq (w_eq),
    .lt (w_lt)
  );

  // Throttle up to 7 steps when slow, brake by at most BRAKE_STEP when fast
  always_comb begin
    w_tormoz   = 1'b0;
    w_pashesh  = 3'd0;
    w_vfelinew = w_vfeli;
    w_up       = w_target - w_vfeli;
    w_dn       = w_vfeli - w_target;
    if (w_lt) begin
      w_pashesh  = (w_up > 8'd7) ? 3'd7 : w_up[2:0];
      w_vfelinew = w_vfeli + {5'd0, w_pashesh};
    end else if (w_gt) begin
      w_tormoz   = 1'b1;
      w_vfelinew = w_vfeli - ((w_dn > c_brake_step) ? c_brake_step : w_dn);
    end
  end

  // Output registers, cleared asynchronously by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tormoz     <= 1'b0;
      r_pashesh    <= 3'd0;
      r_gt         <= 1'b0;
      r_eq         <= 1'b0;
      r_lt         <= 1'b0;
      r_changewire <= 2'b00;
      r_vout1      <= 8'd0;
      r_vfelinew   <= 8'd0;
    end else begin
      r_tormoz     <= w_tormoz;
      r_pashesh    <= w_pashesh;
      r_gt         <= w_gt;
      r_eq         <= w_eq;
      r_lt         <= w_lt;
      r_changewire <= w_change;
      r_vout1      <= w_target;
      r_vfelinew   <= w_vfelinew;
    end
  end

  assign tormoz     = r_tormoz;
  assign pashesh    = r_pashesh;
  assign gt         = r_gt;
  assign eq         = r_eq;
  assign lt         = r_lt;
  assign changewire = r_changewire;
  assign vout1      = r_vout1;
  assign vfelinew   = r_vfelinew;

endmodule : control
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_control
// Purpose  : Directed self-checking bench for the cruise controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] speed = 8'd0;
  logic [7:0] vfeli = 8'd0;
  logic [2:0] hooshyari = 3'd7;
  logic [1:0] change = 2'b00;
  logic       tormoz;
  logic [2:0] pashesh;
  logic       gt;
  logic       eq;
  logic       lt;
  logic [1:0] changewire;
  logic [7:0] vout1;
  logic [7:0] vfelinew;

  int checks = 0;
  int errors = 0;

  control dut (
    .clock      (clock),
    .reset      (reset),
    .speed      (speed),
    .vfeli      (vfeli),
    .hooshyari  (hooshyari),
    .change     (change),
    .tormoz     (tormoz),
    .pashesh    (pashesh),
    .gt         (gt),
    .eq         (eq),
    .lt         (lt),
    .changewire (changewire),
    .vout1      (vout1),
    .vfelinew   (vfelinew)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one vector between edges, then sample just after the next rising edge
  task automatic apply(input logic [7:0] s, input logic [7:0] v,
                       input logic [2:0] h, input logic [1:0] c);
    @(negedge clock);
    speed = s; vfeli = v; hooshyari = h; change = c;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic t, input logic [2:0] p,
                           input logic g, input logic e, input logic l,
                           input logic [1:0] cw, input logic [7:0] v1, input logic [7:0] vn);
    check({tag, ".tormoz"},     {8'd0, tormoz},     {8'd0, t});
    check({tag, ".pashesh"},    {6'd0, pashesh},    {6'd0, p});
    check({tag, ".gt"},         {8'd0, gt},         {8'd0, g});
    check({tag, ".eq"},         {8'd0, eq},         {8'd0, e});
    check({tag, ".lt"},         {8'd0, lt},         {8'd0, l});
    check({tag, ".changewire"}, {7'd0, changewire}, {7'd0, cw});
    check({tag, ".vout1"},      {1'b0, vout1},      {1'b0, v1});
    check({tag, ".vfelinew"},   {1'b0, vfelinew},   {1'b0, vn});
  endtask

  initial begin
    // Reset held across clock edges: everything zero
    speed = 8'd200; vfeli = 8'd200; hooshyari = 3'd7; change = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);

    // First edge after release gives normal outputs
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_all("release", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd200, 8'd200);

    // Increase request, accelerate by 5
    apply(8'd100, 8'd100, 3'd7, 2'b10);
    check_all("up", 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 2'b10, 8'd105, 8'd105);

    // Too fast: brake by BRAKE_STEP
    apply(8'd100, 8'd120, 3'd7, 2'b00);
    check_all("brake", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd100, 8'd116);

    // Increase saturates at MAX_SPEED; throttle caps at 7
    apply(8'd200, 8'd150, 3'd7, 2'b10);
    check_all("sat_hi", 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 2'b10, 8'd200, 8'd157);

    // Decrease saturates at 0
    apply(8'd3, 8'd0, 3'd7, 2'b11);
    check_all("sat_lo", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b11, 8'd0, 8'd0);

    // Resume: target takes the current speed
    apply(8'd50, 8'd80, 3'd7, 2'b01);
    check_all("resume", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b01, 8'd80, 8'd80);

    // Inputs above MAX_SPEED clamp to MAX_SPEED
    apply(8'd250, 8'd255, 3'd7, 2'b00);
    check_all("clamp", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd200, 8'd200);

    // Small overspeed brakes only by the difference
    apply(8'd100, 8'd102, 3'd7, 2'b00);
    check_all("brake_small", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd100, 8'd100);

    // Small underspeed throttles only by the difference
    apply(8'd100, 8'd97, 3'd7, 2'b00);
    check_all("thr_small", 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 2'b00, 8'd100, 8'd100);

    // Drowsy driver asking for more speed
    apply(8'd100, 8'd100, 3'd2, 2'b10);
`ifdef CONTROL_ALERT_EN
    check_all("drowsy_up", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd100, 8'd100);
`else
    check_all("drowsy_up", 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 2'b10, 8'd105, 8'd105);
`endif

    // Drowsy driver may still slow down
    apply(8'd100, 8'd100, 3'd2, 2'b11);
    check_all("drowsy_dn", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 2'b11, 8'd95, 8'd96);

    // Unresponsive driver
    apply(8'd100, 8'd100, 3'd0, 2'b00);
`ifdef CONTROL_ALERT_EN
    check_all("unresp", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 8'd96);
`else
    check_all("unresp", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd100, 8'd100);
`endif

    // Load a non-zero state, then reset between edges must clear at once
    apply(8'd100, 8'd120, 3'd7, 2'b10);
    check_all("pre_async", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 2'b10, 8'd105, 8'd116);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);

    // Recovery after the asynchronous reset
    @(negedge clock);
    reset = 1'b0;
    apply(8'd100, 8'd100, 3'd7, 2'b00);
    check_all("recover", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd100, 8'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_control
`default_nettype wire

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter MAX_SPEED, default 200, is the upper saturation limit for the set speed and the current speed.
REQ-002 Parameter SET_STEP, default 5, is the set-speed change per accepted up/down request.
REQ-003 Parameter BRAKE_STEP, default 4, is the maximum speed reduction per braking cycle.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  rising-edge system clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 speed  input  8  cruise set (target) speed, unsigned.
REQ-008 vfeli  input  8  current vehicle speed, unsigned.
REQ-009 hooshyari  input  3  driver alertness level; 0 = unresponsive, 7 = fully alert.
REQ-010 change  input  2  driver request: 00 none, 10 increase, 11 decrease, 01 resume (set := current).
REQ-011 tormoz  output  1  brake command.
REQ-012 pashesh  output  3  fuel-injection (throttle) level, 0..7.
REQ-013 gt / eq / lt  output  1 each  current speed greater than / equal to / less than the new target; exactly one is high after reset release.
REQ-014 changewire  output  2  registered copy of the effective change request.
REQ-015 vout1  output  8  new set speed (target).
REQ-016 vfelinew  output  8  predicted current speed for the next cycle.

Function
REQ-017 All outputs are registered and update on each rising clock edge from the inputs sampled at that edge, giving one-cycle latency.
REQ-018 Effective change: alertness 0 forces 00; alertness 1..2 turns request 10 into 00; alertness 3..7 passes the request unchanged.
REQ-019 Target: 00 -> speed; 10 -> min(speed+SET_STEP, MAX_SPEED); 11 -> max(speed-SET_STEP, 0); 01 -> vfeli.
REQ-020 At alertness 0, the target is 0 regardless of change.
REQ-021 Arithmetic uses 9-bit intermediates; results saturate at 0 and MAX_SPEED, with no wrap-around.
REQ-022 Compare vfeli with the target, then drive gt/eq/lt one-hot.
REQ-023 When lt: tormoz=0, pashesh=min(target-vfeli, 7), vfelinew=vfeli+pashesh.
REQ-024 When gt: tormoz=1, pashesh=0, vfelinew=vfeli-min(vfeli-target, BRAKE_STEP).
REQ-025 When eq: tormoz=0, pashesh=0, vfelinew=vfeli.
REQ-026 vout1 equals the target; changewire equals the effective change.
REQ-027 Inputs above MAX_SPEED are clamped to MAX_SPEED before any use.

Reset
REQ-028 While reset is high, all outputs are 0, including gt/eq/lt.
REQ-029 The first rising edge after reset deassertion produces normal outputs.
REQ-030 Reset asserted mid-operation clears the outputs immediately, without waiting for a clock edge.

Configuration
REQ-031 With macro CONTROL_ALERT_EN defined, alertness handling (REQ-018, REQ-020) is compiled in.
REQ-032 Without CONTROL_ALERT_EN, hooshyari is ignored and all behaviour is as for alertness 7.

Structure
REQ-033 Shared package control_pkg holds the change-encoding constants, the alertness thresholds (0, 3) and the MAX_SPEED/SET_STEP/BRAKE_STEP defaults.
REQ-034 A combinational sub-module speed_comparator (8-bit a, b -> gt/eq/lt) is instantiated once.
REQ-035 All other logic stays in control.

Verification
REQ-036 Reset asserted -> all outputs 0; release with speed=200, vfeli=200, hooshyari=7, change=00 -> eq=1, vout1=200, vfelinew=200, tormoz=0, pashesh=0.
REQ-037 speed=100, vfeli=100, hooshyari=7, change=10 -> vout1=105, lt=1, pashesh=5, vfelinew=105, changewire=10.
REQ-038 speed=100, vfeli=120, change=00 -> gt=1, tormoz=1, pashesh=0, vfelinew=116.
REQ-039 speed=200, change=10 -> vout1=200 (saturated); speed=3, change=11 -> vout1=0.
REQ-040 hooshyari=010, change=10, speed=vfeli=100 -> changewire=00, vout1=100, eq=1.
REQ-041 hooshyari=000, speed=vfeli=100 -> vout1=0, gt=1, tormoz=1, vfelinew=96.
REQ-042 Without CONTROL_ALERT_EN, hooshyari=000 with speed=vfeli=100 -> vout1=100, eq=1.
